// File: rtl/csr_file_irq.sv
// Machine-mode CSR file: CSR read/write/set/clear, timer/external interrupt take, MRET, mcycle/minstret.
// Latency: reads and redirect are combinational; CSR updates, traps and counters commit at the next clk edge.
// Backpressure: none; interrupts are held off while irq_ready=0, and the pipeline must honour csr_redirect.
module csr_file_irq #(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_reg_rdpin,
  input  logic            csr_reg_wrpin,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_addr32,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_pc,
  input  logic            instr_retired,
  input  logic            is_mret,
  input  logic            irq_ready,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] csr_evec,
  output logic            csr_redirect,
  output logic            csr_illegal
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // MODE[1] is reserved; MODE[0] (vectored) survives only when vectoring is supported.
  localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED_EN ? {{(XLEN-2){1'b1}}, 2'b01}
                                                       : {{(XLEN-2){1'b1}}, 2'b00};

  // Architectural state
  logic             st_mie;
  logic             st_mpie;
  logic             ie_mtie;
  logic             ie_meie;
  logic [XLEN-1:0]  mtvec;
  logic [XLEN-1:0]  mscratch;
  logic [XLEN-1:0]  mepc;
  logic [XLEN-1:0]  mcause;
  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret;
  logic [1:0]       tsync;
  logic [1:0]       esync;

  // Decode / datapath
  logic [11:0]      addr;
  logic             mapped;
  logic [XLEN-1:0]  rd_val;
  logic [XLEN-1:0]  wr_new;
  logic             wr_en;
  logic             mip_mtip;
  logic             mip_meip;
  logic             pend_mei;
  logic             pend_mti;
  logic             take;
  logic             mret;
  logic [3:0]       cause;
  logic [XLEN-1:0]  trap_cause;
  logic [XLEN-1:0]  tvec_base;
  logic [XLEN-1:0]  tvec_off;
  logic [XLEN-1:0]  trap_vec;
  logic             unused_addr_hi;

  assign addr           = csr_addr32[11:0];
  assign unused_addr_hi = ^csr_addr32[XLEN-1:12];

  assign mip_mtip = tsync[1];
  assign mip_meip = esync[1];

  // Read mux: current (pre-edge) value of the addressed CSR, plus the mapped flag
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (addr)
      A_MSTATUS: begin
        rd_val[12:11] = 2'b11;
        rd_val[7]     = st_mpie;
        rd_val[3]     = st_mie;
      end
      A_MIE: begin
        rd_val[11] = ie_meie;
        rd_val[7]  = ie_mtie;
      end
      A_MTVEC:    rd_val = mtvec;
      A_MSCRATCH: rd_val = mscratch;
      A_MEPC:     rd_val = mepc;
      A_MCAUSE:   rd_val = mcause;
      A_MIP: begin
        rd_val[11] = mip_meip;
        rd_val[7]  = mip_mtip;
      end
      A_MCYCLE:   rd_val = XLEN'(mcycle[31:0]);
      A_MINSTRET: rd_val = XLEN'(minstret[31:0]);
      A_MCYCLEH:  rd_val = XLEN'(mcycle[CNT_W-1:32]);
      A_MINSTRH:  rd_val = XLEN'(minstret[CNT_W-1:32]);
      default:    mapped = 1'b0;
    endcase
  end

  // Read-modify-write operand: per-register masks are applied at the destination
  always_comb begin
    wr_new = rd_val;
    case (csr_op)
      OP_WRITE: wr_new = csr_wdata;
      OP_SET:   wr_new = rd_val | csr_wdata;
      OP_CLEAR: wr_new = rd_val & ~csr_wdata;
      default:  wr_new = rd_val;
    endcase
  end

  assign wr_en = csr_reg_wrpin & mapped & (csr_op != 2'b00);

  // Interrupt arbitration and redirect target; external beats timer
  always_comb begin
    pend_mei   = mip_meip & ie_meie;
    pend_mti   = mip_mtip & ie_mtie;
    take       = st_mie & irq_ready & (pend_mei | pend_mti);
    mret       = is_mret & ~take;
    cause      = pend_mei ? 4'd11 : 4'd7;
    trap_cause = {1'b1, {(XLEN-5){1'b0}}, cause};
    tvec_base  = {mtvec[XLEN-1:2], 2'b00};
    tvec_off   = {{(XLEN-6){1'b0}}, cause, 2'b00};
    trap_vec   = mtvec[0] ? (tvec_base + tvec_off) : tvec_base;
  end

  // Outputs are forced low while reset is held so nothing leaks into the PC mux
  always_comb begin
    csr_rdata    = '0;
    csr_evec     = '0;
    csr_redirect = 1'b0;
    csr_illegal  = 1'b0;
    if (rst_n) begin
      csr_rdata    = (csr_reg_rdpin & mapped) ? rd_val : '0;
      csr_illegal  = (csr_reg_rdpin | csr_reg_wrpin) & ~mapped;
      csr_redirect = take | mret;
      if (take) begin
        csr_evec = trap_vec;
      end else if (mret) begin
        csr_evec = mepc;
      end
    end
  end

  // Two-flop synchronisers for the asynchronous interrupt levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tsync <= 2'b00;
      esync <= 2'b00;
    end else begin
      tsync <= {tsync[0], timer_irq};
      esync <= {esync[0], ext_irq};
    end
  end

  // Trap/return state: a trap or MRET overrides any CSR write to these registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      mepc    <= '0;
      mcause  <= '0;
    end else if (take) begin
      mepc    <= {csr_pc[XLEN-1:2], 2'b00};
      mcause  <= trap_cause;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr_en) begin
      case (addr)
        A_MSTATUS: begin
          st_mie  <= wr_new[3];
          st_mpie <= wr_new[7];
        end
        A_MEPC:   mepc   <= {wr_new[XLEN-1:2], 2'b00};
        A_MCAUSE: mcause <= wr_new;
        default:  ;
      endcase
    end
  end

  // Plain CSRs unaffected by trap sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_mtie  <= 1'b0;
      ie_meie  <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
    end else if (wr_en) begin
      case (addr)
        A_MIE: begin
          ie_mtie <= wr_new[7];
          ie_meie <= wr_new[11];
        end
        A_MTVEC:    mtvec    <= wr_new & MTVEC_MASK;
        A_MSCRATCH: mscratch <= wr_new;
        default:    ;
      endcase
    end
  end

  // mcycle: free-running; a write to either half replaces it and skips that cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle <= '0;
    end else if (wr_en && addr == A_MCYCLE) begin
      mcycle[31:0] <= wr_new[31:0];
    end else if (wr_en && addr == A_MCYCLEH) begin
      mcycle[CNT_W-1:32] <= wr_new[CNT_W-33:0];
    end else begin
      mcycle <= mcycle + CNT_W'(1);
    end
  end

  // minstret: counts retirements; a write to either half wins over the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minstret <= '0;
    end else if (wr_en && addr == A_MINSTRET) begin
      minstret[31:0] <= wr_new[31:0];
    end else if (wr_en && addr == A_MINSTRH) begin
      minstret[CNT_W-1:32] <= wr_new[CNT_W-33:0];
    end else if (instr_retired) begin
      minstret <= minstret + CNT_W'(1);
    end
  end

endmodule
